cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_pkg.sv | 33 +++
 rtl/cdb_fifo.sv | 68 ++++++
 rtl/cdb_arbiter.sv | 149 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared word layout, unit codes and one-hot register codes for the common data bus arbiter.
package cdb_pkg;

  localparam int DEST_MSB = 15;
  localparam int DEST_LSB = 13;
  localparam int RS_MSB   = 12;
  localparam int RS_LSB   = 11;
  localparam int UNIT_BIT = 10;
  localparam int DATA_MSB = 9;
  localparam int DATA_LSB = 0;

  typedef logic [15:0] cdb_word_t;

  localparam cdb_word_t  INVALID_WORD = 16'hFFFF;
  localparam logic       UNIT_ULA     = 1'b1;
  localparam logic       UNIT_LDSD    = 1'b0;
  localparam logic [2:0] R0           = 3'b100;
  localparam logic [2:0] R1           = 3'b010;
  localparam logic [2:0] R2           = 3'b001;

  typedef enum logic {
    SRC_LDSD = 1'b0,
    SRC_ULA  = 1'b1
  } src_e;

  // A word is accepted only with a single destination register and the unit tag of its port.
  function automatic logic is_well_formed(input cdb_word_t w, input logic unit);
    logic [2:0] dest;
    dest = w[DEST_MSB:DEST_LSB];
    return ((dest == R0) || (dest == R1) || (dest == R2)) && (w[UNIT_BIT] == unit);
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Synchronous per-source result queue; a push into a full queue is taken only when the head
// leaves on the same edge.
module cdb_fifo
  import cdb_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  cdb_word_t     din,
  output cdb_word_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  cdb_word_t     mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify requests against the current occupancy.
  always_comb begin
    do_pop_s  = pop && (count_r != {CW{1'b0}});
    do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
  end

  // Pointer and occupancy update; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care while the queue is empty.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});
  assign count = count_r;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter merging arithmetic and load/store results onto one registered bus.
// Optional statistics counters are enabled with the macro CDB_ARB_STATS_EN.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] ula_in,
  input  logic [15:0] ldsd_in,
  output logic        ula_stall,
  output logic        ldsd_stall,
  output logic [15:0] cdb,
  output logic        cdb_valid,
  output logic [2:0]  reg_we,
  output logic [9:0]  reg_wdata,
  output logic        err_overflow,
  output logic        err_format
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [15:0] bcast_count,
  output logic [15:0] conflict_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  src_e          last_grant_r;
  logic          ula_push_s,  ldsd_push_s;
  logic          ula_fmt_s,   ldsd_fmt_s;
  logic          ula_ovf_s,   ldsd_ovf_s;
  logic          ula_pop_s,   ldsd_pop_s;
  cdb_word_t     ula_head_s,  ldsd_head_s;
  logic          ula_full_s,  ldsd_full_s;
  logic          ula_empty_s, ldsd_empty_s;
  logic [CW-1:0] ula_count_s, ldsd_count_s;

  // Classify incoming words as idle, well-formed pushes or malformed discards.
  always_comb begin
    ula_push_s  = (ula_in != INVALID_WORD) && is_well_formed(ula_in, UNIT_ULA);
    ula_fmt_s   = (ula_in != INVALID_WORD) && !is_well_formed(ula_in, UNIT_ULA);
    ldsd_push_s = (ldsd_in != INVALID_WORD) && is_well_formed(ldsd_in, UNIT_LDSD);
    ldsd_fmt_s  = (ldsd_in != INVALID_WORD) && !is_well_formed(ldsd_in, UNIT_LDSD);
    ula_ovf_s   = ula_push_s && ula_full_s && !ula_pop_s;
    ldsd_ovf_s  = ldsd_push_s && ldsd_full_s && !ldsd_pop_s;
  end

  // Grant selection: a tie goes to whichever source was not served last.
  always_comb begin
    ula_pop_s  = 1'b0;
    ldsd_pop_s = 1'b0;
    if (!ula_empty_s && !ldsd_empty_s) begin
      if (last_grant_r == SRC_LDSD) begin
        ula_pop_s = 1'b1;
      end else begin
        ldsd_pop_s = 1'b1;
      end
    end else if (!ula_empty_s) begin
      ula_pop_s = 1'b1;
    end else if (!ldsd_empty_s) begin
      ldsd_pop_s = 1'b1;
    end else begin
      ula_pop_s  = 1'b0;
      ldsd_pop_s = 1'b0;
    end
  end

  cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_ula_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (ula_push_s),
    .pop     (ula_pop_s),
    .din     (ula_in),
    .head    (ula_head_s),
    .full    (ula_full_s),
    .empty   (ula_empty_s),
    .count   (ula_count_s)
  );

  cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_ldsd_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (ldsd_push_s),
    .pop     (ldsd_pop_s),
    .din     (ldsd_in),
    .head    (ldsd_head_s),
    .full    (ldsd_full_s),
    .empty   (ldsd_empty_s),
    .count   (ldsd_count_s)
  );

  // Broadcast register, grant history and sticky error flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cdb          <= INVALID_WORD;
      cdb_valid    <= 1'b0;
      reg_we       <= 3'b000;
      reg_wdata    <= 10'd0;
      last_grant_r <= SRC_LDSD;
      err_overflow <= 1'b0;
      err_format   <= 1'b0;
    end else begin
      if (ula_pop_s) begin
        cdb          <= ula_head_s;
        cdb_valid    <= 1'b1;
        reg_we       <= ula_head_s[DEST_MSB:DEST_LSB];
        reg_wdata    <= ula_head_s[DATA_MSB:DATA_LSB];
        last_grant_r <= SRC_ULA;
      end else if (ldsd_pop_s) begin
        cdb          <= ldsd_head_s;
        cdb_valid    <= 1'b1;
        reg_we       <= ldsd_head_s[DEST_MSB:DEST_LSB];
        reg_wdata    <= ldsd_head_s[DATA_MSB:DATA_LSB];
        last_grant_r <= SRC_LDSD;
      end else begin
        cdb          <= INVALID_WORD;
        cdb_valid    <= 1'b0;
        reg_we       <= 3'b000;
        reg_wdata    <= 10'd0;
        last_grant_r <= last_grant_r;
      end
      err_overflow <= err_overflow | ula_ovf_s | ldsd_ovf_s;
      err_format   <= err_format | ula_fmt_s | ldsd_fmt_s;
    end
  end

  // One free slot remains when stall rises, covering a producer that already issued.
  assign ula_stall  = (ula_count_s >= CW'(FIFO_DEPTH - 1));
  assign ldsd_stall = (ldsd_count_s >= CW'(FIFO_DEPTH - 1));

`ifdef CDB_ARB_STATS_EN
  // Saturating statistics; a broadcast is counted on the edge that registers it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bcast_count    <= 16'd0;
      conflict_count <= 16'd0;
    end else begin
      if ((ula_pop_s || ldsd_pop_s) && (bcast_count != 16'hFFFF)) begin
        bcast_count <= bcast_count + 16'd1;
      end
      if (!ula_empty_s && !ldsd_empty_s && (conflict_count != 16'hFFFF)) begin
        conflict_count <= conflict_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-level reference model predicts every broadcast.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] ula_in = 16'hFFFF;
  logic [15:0] ldsd_in = 16'hFFFF;
  logic        ula_stall, ldsd_stall, cdb_valid, err_overflow, err_format;
  logic [15:0] cdb;
  logic [2:0]  reg_we;
  logic [9:0]  reg_wdata;
`ifdef CDB_ARB_STATS_EN
  logic [15:0] bcast_count, conflict_count;
  int          m_bc = 0;
  int          m_cf = 0;
`endif

  always #5 clock = ~clock;

  cdb_arbiter #(.FIFO_DEPTH(D)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ula_in       (ula_in),
    .ldsd_in      (ldsd_in),
    .ula_stall    (ula_stall),
    .ldsd_stall   (ldsd_stall),
    .cdb          (cdb),
    .cdb_valid    (cdb_valid),
    .reg_we       (reg_we),
    .reg_wdata    (reg_wdata),
    .err_overflow (err_overflow),
    .err_format   (err_format)
`ifdef CDB_ARB_STATS_EN
    ,
    .bcast_count    (bcast_count),
    .conflict_count (conflict_count)
`endif
  );

  // Reference model state: plain queues of accepted words per source.
  logic [15:0] mq_ula[$];
  logic [15:0] mq_ldsd[$];
  logic [15:0] exp_q[$];
  bit          m_last_ula = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_fmt = 1'b0;
  bit          chk_en = 1'b0;
  bit          drain_chk = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic bit good_word(input logic [15:0] w, input bit unit);
    return ($countones(w[15:13]) == 1) && (w[10] == unit);
  endfunction

  task automatic model_push(input logic [15:0] w, input bit unit);
    if (w != 16'hFFFF) begin
      if (!good_word(w, unit)) m_fmt = 1'b1;
      else if (unit && mq_ula.size() < D) mq_ula.push_back(w);
      else if (!unit && mq_ldsd.size() < D) mq_ldsd.push_back(w);
      else m_ovf = 1'b1;
    end
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_step();
    bit ne_u, ne_l;
    if (!reset_n) begin
      mq_ula.delete();
      mq_ldsd.delete();
      m_last_ula = 1'b0;
      m_ovf = 1'b0;
      m_fmt = 1'b0;
`ifdef CDB_ARB_STATS_EN
      m_bc = 0;
      m_cf = 0;
`endif
    end else begin
      ne_u = mq_ula.size() > 0;
      ne_l = mq_ldsd.size() > 0;
`ifdef CDB_ARB_STATS_EN
      if (ne_u && ne_l && m_cf < 65535) m_cf++;
      if ((ne_u || ne_l) && m_bc < 65535) m_bc++;
`endif
      if (ne_u && (!ne_l || !m_last_ula)) begin
        exp_q.push_back(mq_ula.pop_front());
        m_last_ula = 1'b1;
      end else if (ne_l) begin
        exp_q.push_back(mq_ldsd.pop_front());
        m_last_ula = 1'b0;
      end
      model_push(ula_in, 1'b1);
      model_push(ldsd_in, 1'b0);
    end
  endtask

  task automatic cyc(input logic [15:0] u, input logic [15:0] l, input logic rn);
    @(negedge clock);
    ula_in  = u;
    ldsd_in = l;
    reset_n = rn;
    @(posedge clock);
    model_step();
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the bus carries a word, else checks the idle value.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clock);
      if (chk_en) begin
        if (cdb_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_bcast", cdb, 16'hFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("cdb_word", cdb, e);
            chk("reg_we", {13'd0, reg_we}, {13'd0, e[15:13]});
            chk("reg_wdata", {6'd0, reg_wdata}, {6'd0, e[9:0]});
          end
        end else begin
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("missing_bcast", {15'd0, cdb_valid}, 16'd1);
          end else begin
            chk("idle_cdb", cdb, 16'hFFFF);
            chk("idle_we_wdata", {3'd0, reg_we, reg_wdata}, 16'd0);
          end
        end
        chk("ula_stall", {15'd0, ula_stall}, {15'd0, mq_ula.size() >= D - 1});
        chk("ldsd_stall", {15'd0, ldsd_stall}, {15'd0, mq_ldsd.size() >= D - 1});
        chk("err_overflow", {15'd0, err_overflow}, {15'd0, m_ovf});
        chk("err_format", {15'd0, err_format}, {15'd0, m_fmt});
`ifdef CDB_ARB_STATS_EN
        chk("bcast_count", bcast_count, 16'(m_bc));
        chk("conflict_count", conflict_count, 16'(m_cf));
`endif
        if (drain_chk) chk("drain_empty", 16'(exp_q.size()), 16'd0);
      end
    end
  end

  function automatic logic [15:0] mk(input int dsel, input bit unit, input logic [9:0] data);
    logic [2:0] dest;
    dest = (dsel == 0) ? R0 : (dsel == 1) ? R1 : R2;
    return {dest, 2'($urandom_range(0, 3)), unit, data};
  endfunction

  function automatic logic [15:0] rnd_word(input bit unit, input bit stalled, input bit honor);
    int r;
    r = $urandom_range(0, 9);
    if (honor && stalled) return 16'hFFFF;
    if (r < 3) return 16'hFFFF;
    if (r == 3) return 16'($urandom);
    return mk($urandom_range(0, 2), unit, 10'($urandom));
  endfunction

  // Stimulus: directed scenarios first, then randomized traffic with occasional resets.
  initial begin
    logic [15:0] w;
    cyc(16'hFFFF, 16'hFFFF, 1'b0);
    chk_en = 1'b1;
    cyc(16'hFFFF, 16'hFFFF, 1'b0);

    w = 16'b1000110000000101;
    cyc(w, 16'hFFFF, 1'b1);
    repeat (3) cyc(16'hFFFF, 16'hFFFF, 1'b1);

    cyc(mk(1, 1'b1, 10'd17), mk(2, 1'b0, 10'd34), 1'b1);
    cyc(mk(0, 1'b1, 10'd51), 16'hFFFF, 1'b1);
    repeat (4) cyc(16'hFFFF, 16'hFFFF, 1'b1);

    w = 16'b1100000000000001;
    cyc(16'hFFFF, w, 1'b1);
    w = 16'b0100010000000011;
    cyc(16'hFFFF, w, 1'b1);
    repeat (2) cyc(16'hFFFF, 16'hFFFF, 1'b1);

    for (int i = 0; i < 14; i++) begin
      cyc(mk(i % 3, 1'b1, 10'(i)), mk((i + 1) % 3, 1'b0, 10'(100 + i)), 1'b1);
    end
    repeat (10) cyc(16'hFFFF, 16'hFFFF, 1'b1);

    cyc(mk(0, 1'b1, 10'd1), mk(1, 1'b0, 10'd2), 1'b1);
    cyc(mk(2, 1'b1, 10'd3), mk(0, 1'b0, 10'd4), 1'b1);
    cyc(16'hFFFF, 16'hFFFF, 1'b0);
    repeat (4) cyc(16'hFFFF, 16'hFFFF, 1'b1);

    for (int i = 0; i < 400; i++) begin
      bit honor;
      honor = ((i / 50) % 2) == 0;
      cyc(rnd_word(1'b1, ula_stall, honor), rnd_word(1'b0, ldsd_stall, honor),
          ($urandom_range(0, 59) != 0));
    end

    repeat (12) cyc(16'hFFFF, 16'hFFFF, 1'b1);
    drain_chk = 1'b1;
    @(negedge clock);
    @(posedge clock);
    drain_chk = 1'b0;
    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
